wiener_uart_frame_scheduler: RTL and testbench

Sequencer that raster-scans a SRC_W×SRC_H greyscale frame out of the image ROM, sources each pixel either directly from the ROM (bypass) or from the Wiener filter output, and hands bytes one at a time to the UART transmitter using its strobe/busy handshake. It sits in the pixel-clock domain between the ROM and Wiener filter and the UART TX. It owns `addr_r`, `src_x`, `src_y`, `pixel_reg` and `send_strobe`. Each frame is preceded by a two-byte sync header so the host can re-align.

---
 rtl/wiener_uart_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_wiener_uart_frame_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wiener_uart_frame_scheduler.sv
// Raster-scans the source frame, picks ROM or Wiener-filter pixels, and feeds
// bytes to the UART TX via strobe/busy handshake, each frame led by a sync header.
module wiener_uart_frame_scheduler #(
  parameter int unsigned SRC_W    = 320,
  parameter int unsigned SRC_H    = 240,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned FILT_LAT = 4,
  parameter logic [7:0]  SYNC0    = 8'hAA,
  parameter logic [7:0]  SYNC1    = 8'h55
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              sw_bypass,
  input  logic [7:0]        rom_q,
  input  logic [7:0]        filt_q,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] addr_r,
  output logic [8:0]        src_x,
  output logic [7:0]        src_y,
  output logic [7:0]        pixel_reg,
  output logic              send_strobe,
  output logic              frame_done,
  output logic              mode_lat
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, FETCH, ISSUE, ACK, DRAIN, NEXT} state_t;

  localparam logic [8:0] X_LAST    = 9'(SRC_W - 1);
  localparam logic [7:0] Y_LAST    = 8'(SRC_H - 1);
  localparam logic [7:0] ROM_WAIT  = 8'(ROM_LAT - 1);
  localparam logic [7:0] FILT_WAIT = 8'(FILT_LAT - 1);

  state_t              state, state_n, ret, ret_n;
  logic [7:0]          wait_cnt, wait_n;
  logic [1:0]          ack_cnt, ack_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [8:0]          x_n;
  logic [7:0]          y_n, pix_n;
  logic                strobe_n, done_n, mode_n;
  logic                last_px;
  logic [7:0]          lat_load;

  assign last_px  = (src_x == X_LAST) && (src_y == Y_LAST);
  assign lat_load = mode_lat ? ROM_WAIT : FILT_WAIT;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ret         <= IDLE;
      wait_cnt    <= '0;
      ack_cnt     <= '0;
      addr_r      <= '0;
      src_x       <= '0;
      src_y       <= '0;
      pixel_reg   <= '0;
      send_strobe <= 1'b0;
      frame_done  <= 1'b0;
      mode_lat    <= 1'b0;
    end else begin
      state       <= state_n;
      ret         <= ret_n;
      wait_cnt    <= wait_n;
      ack_cnt     <= ack_n;
      addr_r      <= addr_n;
      src_x       <= x_n;
      src_y       <= y_n;
      pixel_reg   <= pix_n;
      send_strobe <= strobe_n;
      frame_done  <= done_n;
      mode_lat    <= mode_n;
    end
  end

  // ret holds where DRAIN goes next: HDR1 after SYNC0, FETCH after SYNC1, NEXT after a pixel.
  always_comb begin
    state_n  = state;
    ret_n    = ret;
    wait_n   = wait_cnt;
    ack_n    = ack_cnt;
    addr_n   = addr_r;
    x_n      = src_x;
    y_n      = src_y;
    pix_n    = pixel_reg;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    mode_n   = mode_lat;
    case (state)
      IDLE: begin
        if (run) begin
          addr_n  = '0;
          x_n     = '0;
          y_n     = '0;
          mode_n  = sw_bypass;
          state_n = HDR0;
        end
      end
      HDR0: begin
        pix_n   = SYNC0;
        ret_n   = HDR1;
        state_n = ISSUE;
      end
      HDR1: begin
        pix_n   = SYNC1;
        ret_n   = FETCH;
        state_n = ISSUE;
      end
      FETCH: begin
        if (wait_cnt == 8'd0) begin
          pix_n   = mode_lat ? rom_q : filt_q;
          ret_n   = NEXT;
          state_n = ISSUE;
        end else begin
          wait_n = wait_cnt - 8'd1;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          strobe_n = 1'b1;
          ack_n    = '0;
          state_n  = ACK;
        end
      end
      ACK: begin
        if (tx_busy || ack_cnt == 2'd3) state_n = DRAIN;
        else                            ack_n   = ack_cnt + 2'd1;
      end
      DRAIN: begin
        if (!tx_busy) begin
          state_n = ret;
          if (ret == FETCH) wait_n = lat_load;
          // Raised on entry so the pulse lands in the NEXT cycle of the last pixel.
          if (ret == NEXT && last_px) done_n = 1'b1;
        end
      end
      NEXT: begin
        if (!last_px) begin
          addr_n  = addr_r + ADDR_W'(1);
          wait_n  = lat_load;
          state_n = FETCH;
          if (src_x != X_LAST) begin
            x_n = src_x + 9'd1;
          end else begin
            x_n = '0;
            y_n = src_y + 8'd1;
          end
        end else if (run) begin
          addr_n  = '0;
          x_n     = '0;
          y_n     = '0;
          mode_n  = sw_bypass;
          state_n = HDR0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wiener_uart_frame_scheduler.sv
// Randomized bench for wiener_uart_frame_scheduler on a small 6x4 frame with a
// byte-stream reference model, a randomized UART busy mock and latency-modelled ROM/filter.
module tb_wiener_uart_frame_scheduler;

  localparam int W      = 6;
  localparam int H      = 4;
  localparam int NPIX   = W * H;
  localparam int AW     = 5;

  logic          pclk = 1'b0;
  logic          reset_n = 1'b1;
  logic          run = 1'b0;
  logic          sw_bypass = 1'b1;
  logic [7:0]    rom_q, filt_q;
  logic          tx_busy;
  logic [AW-1:0] addr_r;
  logic [8:0]    src_x;
  logic [7:0]    src_y, pixel_reg;
  logic          send_strobe, frame_done, mode_lat;

  logic          hold_busy = 1'b0;
  int            busy_cnt = 0;
  logic [AW-1:0] rom_a;
  logic [AW-1:0] fpipe [3];

  int n_checks = 0;
  int n_fail   = 0;
  int idx      = 0;
  int strobes  = 0;
  int frames   = 0;
  logic frame_mode = 1'b0;
  logic prev_strobe = 1'b0;
  logic prev_done = 1'b0;

  wiener_uart_frame_scheduler #(
    .SRC_W(W), .SRC_H(H), .ADDR_W(AW), .ROM_LAT(2), .FILT_LAT(4),
    .SYNC0(8'hAA), .SYNC1(8'h55)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .run(run), .sw_bypass(sw_bypass),
    .rom_q(rom_q), .filt_q(filt_q), .tx_busy(tx_busy),
    .addr_r(addr_r), .src_x(src_x), .src_y(src_y), .pixel_reg(pixel_reg),
    .send_strobe(send_strobe), .frame_done(frame_done), .mode_lat(mode_lat)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] rom_fn(input int k);
    return 8'((k % W) ^ (k / W));
  endfunction

  function automatic logic [7:0] filt_fn(input int k);
    return 8'(k * 37 + 11);
  endfunction

  // Data for an address becomes sampleable on the LAT-th edge after the address changes.
  always @(posedge pclk) begin
    rom_a    <= addr_r;
    fpipe[0] <= addr_r;
    fpipe[1] <= fpipe[0];
    fpipe[2] <= fpipe[1];
  end
  assign rom_q  = rom_fn(int'(rom_a));
  assign filt_q = filt_fn(int'(fpipe[2]));

  // UART mock: a zero-length busy models a TX that never raises busy.
  always @(posedge pclk) begin
    if (send_strobe)       busy_cnt <= $urandom_range(0, 6);
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (!reset_n) begin
      idx         = 0;
      prev_strobe = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (send_strobe) begin
        check("no_back_to_back", 32'(prev_strobe), 32'd0);
        check("busy_at_strobe", 32'(tx_busy), 32'd0);
        if (idx == 0) begin
          frame_mode = sw_bypass;
          check("hdr0_byte", 32'(pixel_reg), 32'hAA);
          check("hdr0_addr", 32'(addr_r), 32'd0);
        end else if (idx == 1) begin
          check("hdr1_byte", 32'(pixel_reg), 32'h55);
          check("hdr1_addr", 32'(addr_r), 32'd0);
        end else begin
          check("pix_byte", 32'(pixel_reg),
                32'(frame_mode ? rom_fn(idx - 2) : filt_fn(idx - 2)));
          check("pix_addr", 32'(addr_r), 32'(idx - 2));
          check("pix_x", 32'(src_x), 32'((idx - 2) % W));
          check("pix_y", 32'(src_y), 32'((idx - 2) / W));
        end
        check("mode_lat", 32'(mode_lat), 32'(frame_mode));
        idx++;
        strobes++;
      end
      if (frame_done) begin
        check("done_pulse", 32'(prev_done), 32'd0);
        check("frame_len", 32'(idx), 32'(2 + NPIX));
        check("done_addr", 32'(addr_r), 32'(NPIX - 1));
        check("done_x", 32'(src_x), 32'(W - 1));
        check("done_y", 32'(src_y), 32'(H - 1));
        idx = 0;
        frames++;
      end
      prev_strobe = send_strobe;
      prev_done   = frame_done;
    end
  end

  task automatic wait_idx(input int target, input int budget);
    int n = 0;
    while (idx != target && n < budget) begin
      @(posedge pclk);
      n++;
    end
    if (idx != target) check("wait_idx_timeout", 32'(idx), 32'(target));
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(posedge pclk);
      n++;
    end
    if (frames < target) check("wait_frame_timeout", 32'(frames), 32'(target));
  endtask

  task automatic check_reset_values();
    check("rst_addr", 32'(addr_r), 32'd0);
    check("rst_x", 32'(src_x), 32'd0);
    check("rst_y", 32'(src_y), 32'd0);
    check("rst_pixel", 32'(pixel_reg), 32'd0);
    check("rst_strobe", 32'(send_strobe), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_mode", 32'(mode_lat), 32'd0);
  endtask

  initial begin
    int s;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1 check_reset_values();
    reset_n = 1'b1;
    repeat (5) @(posedge pclk);
    #1 check("idle_no_strobe", 32'(strobes), 32'd0);

    // Frame 1 in bypass; switch requested mid-frame must wait for frame 2.
    run = 1'b1;
    wait_idx(8, 2000);
    #1 sw_bypass = 1'b0;
    repeat (3) @(posedge pclk);
    #1 check("mode_kept_midframe", 32'(mode_lat), 32'd1);
    wait_frames(1, 4000);

    // Frame 2 filtered; stall the UART for 100 cycles.
    wait_idx(10, 2000);
    #1 hold_busy = 1'b1;
    s = strobes;
    repeat (100) @(posedge pclk);
    #1 check("no_strobe_while_busy", 32'(strobes - s), 32'd0);
    hold_busy = 1'b0;
    wait_idx(15, 2000);
    #1 sw_bypass = 1'b1;
    wait_frames(2, 4000);
    #1 check("mode_filter_frame", 32'(frame_mode), 32'd0);

    // Frame 3: asynchronous reset mid-pixel, then restart.
    wait_idx(12, 2000);
    @(posedge pclk);
    #1 reset_n = 1'b0;
    #1 check_reset_values();
    repeat (3) @(posedge pclk);
    #1 reset_n = 1'b1;

    // Drop run mid-frame: the frame finishes, then the block idles.
    wait_idx(8, 2000);
    #1 run = 1'b0;
    s = frames;
    wait_frames(s + 1, 4000);
    s = strobes;
    repeat (50) @(posedge pclk);
    #1 check("idle_after_run_low", 32'(strobes - s), 32'd0);
    check("idle_addr_held", 32'(addr_r), 32'(NPIX - 1));
    check("frames_total", 32'(frames), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d frames expected 3", frames);
    $fatal(1);
  end

endmodule
